// File: rtl/ir_pkg.sv
// Shared definitions for the IR line classifier.
//   NUM_CH      number of IR channels
//   TTD_W_DEF   default width of one ttd value
//   cal_state_e calibration FSM encoding
//   *_MASK      line-pattern masks over ir_color
//   popcount4   helper for the left/right black counts
package ir_pkg;

  localparam int unsigned NUM_CH    = 8;
  localparam int unsigned TTD_W_DEF = 17;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StScan,
    StCommit
  } cal_state_e;

  localparam logic [7:0] LEFT_MASK  = 8'hF0;
  localparam logic [7:0] RIGHT_MASK = 8'h0F;
  localparam logic [7:0] TRACK_MASK = 8'h18;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/flag_debounce.sv
// Debounces one flag: out follows raw only after raw has differed from out
// for DB_CYCLES consecutive clocks.
//   clk   in  system clock (posedge)
//   rst_n in  asynchronous active-low reset
//   raw   in  undebounced flag
//   out   out debounced flag, 0 after reset
module flag_debounce #(
  parameter int unsigned DB_CYCLES = 1600000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out
);

  localparam int unsigned     CntW    = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (raw == out_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntLast) begin
      out_d = raw;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/ir_line_classifier.sv
// IR line classifier: calibrates a black/white threshold from sampled ttd values,
// classifies the 8 channels per sample and emits debounced line patterns.
// Optional feature: define IR_HYST_EN to compare each channel against threshold-HYST
// when it is currently black and threshold+HYST when white (saturating).
//   WF_CLK     in  system clock
//   rst_n      in  asynchronous active-low reset
//   ttd_bus    in  8 packed ttd values, ch0 in the low bits
//   sample_stb in  fresh sample on ttd_bus
//   cal_req    in  start calibration (ignored while busy)
//   cal_busy   out calibration in progress
//   cal_done   out pulse when the new threshold becomes visible
//   threshold  out active threshold
//   ir_color   out per-channel black flags, color_vld pulses on update
//   on_track/left/right/lost  out debounced patterns
//   left_sum/right_sum        out black counts of the upper/lower nibble
module ir_line_classifier
  import ir_pkg::*;
#(
  parameter int unsigned       TTD_W          = TTD_W_DEF,
  parameter int unsigned       CAL_SAMPLES    = 16,
  parameter int unsigned       DB_CYCLES      = 1600000,
  parameter logic [TTD_W-1:0]  THRESH_DEFAULT = TTD_W'(2000),
  parameter logic [TTD_W-1:0]  HYST           = TTD_W'(100)
) (
  input  logic                    WF_CLK,
  input  logic                    rst_n,
  input  logic [NUM_CH*TTD_W-1:0] ttd_bus,
  input  logic                    sample_stb,
  input  logic                    cal_req,
  output logic                    cal_busy,
  output logic                    cal_done,
  output logic [TTD_W-1:0]        threshold,
  output logic [NUM_CH-1:0]       ir_color,
  output logic                    color_vld,
  output logic                    on_track,
  output logic                    left,
  output logic                    right,
  output logic                    lost,
  output logic [2:0]              left_sum,
  output logic [2:0]              right_sum
);

`ifdef IR_HYST_EN
  localparam bit HystEn = 1'b1;
`else
  localparam bit HystEn = 1'b0;
`endif

  localparam int unsigned ChW = $clog2(NUM_CH);
  localparam int unsigned NW  = (CAL_SAMPLES > 1) ? $clog2(CAL_SAMPLES) : 1;
  localparam logic [NW-1:0]  NLast  = NW'(CAL_SAMPLES - 1);
  localparam logic [ChW-1:0] ChLast = ChW'(NUM_CH - 1);

  logic [TTD_W-1:0] ttd_ch [NUM_CH];
  logic [TTD_W-1:0] samp_q [NUM_CH];

  cal_state_e       state_q, state_d;
  logic [TTD_W-1:0] min_q, min_d, max_q, max_d;
  logic [TTD_W-1:0] thr_q, thr_d;
  logic [NW-1:0]    n_q, n_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic             done_q, done_d;
  logic             cap_en;
  logic [TTD_W-1:0] cal_val;
  logic [TTD_W+1:0] cal_sum;

  logic [NUM_CH-1:0] color_q, color_d;
  logic              vld_q;
  logic [TTD_W:0]    thr_up;
  logic [TTD_W-1:0]  thr_hi, thr_lo;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ttd_ch[g] = ttd_bus[g*TTD_W +: TTD_W];
  end

  // Classification -------------------------------------------------------------------

  assign thr_up = {1'b0, thr_q} + {1'b0, HYST};
  assign thr_hi = thr_up[TTD_W] ? '1 : thr_up[TTD_W-1:0];
  assign thr_lo = (thr_q > HYST) ? (thr_q - HYST) : '0;

  always_comb begin
    color_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!HystEn) begin
        color_d[i] = ttd_ch[i] > thr_q;
      end else if (color_q[i]) begin
        color_d[i] = ttd_ch[i] > thr_lo;
      end else begin
        color_d[i] = ttd_ch[i] > thr_hi;
      end
    end
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      color_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= sample_stb;
      if (sample_stb) color_q <= color_d;
    end
  end

  // Calibration FSM ------------------------------------------------------------------

  assign cal_val = samp_q[ch_q];
  // 3*min + max in TTD_W+2 bits cannot overflow; divide by 4 via the slice.
  assign cal_sum = ({2'b00, min_q} << 1) + {2'b00, min_q} + {2'b00, max_q};

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    n_d     = n_q;
    ch_d    = ch_q;
    thr_d   = thr_q;
    done_d  = 1'b0;
    cap_en  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cal_req) begin
          state_d = StWait;
          min_d   = '1;
          max_d   = '0;
          n_d     = '0;
        end
      end
      StWait: begin
        if (sample_stb) begin
          state_d = StScan;
          ch_d    = '0;
          cap_en  = 1'b1;
        end
      end
      StScan: begin
        if (cal_val < min_q) min_d = cal_val;
        if (cal_val > max_q) max_d = cal_val;
        ch_d = ch_q + 1'b1;
        if (ch_q == ChLast) begin
          if (n_q == NLast) begin
            state_d = StCommit;
          end else begin
            n_d     = n_q + 1'b1;
            state_d = StWait;
          end
        end
      end
      StCommit: begin
        thr_d   = cal_sum[TTD_W+1:2];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      min_q   <= '0;
      max_q   <= '0;
      n_q     <= '0;
      ch_q    <= '0;
      thr_q   <= THRESH_DEFAULT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      n_q     <= n_d;
      ch_q    <= ch_d;
      thr_q   <= thr_d;
      done_q  <= done_d;
    end
  end

  // Calibration works on a frozen copy so later samples cannot disturb a scan.
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) samp_q[i] <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_CH; i++) samp_q[i] <= ttd_ch[i];
    end
  end

  // Pattern debouncers ---------------------------------------------------------------

  logic track_raw, left_raw, right_raw, lost_raw;

  assign track_raw = (color_q & TRACK_MASK) == TRACK_MASK;
  assign left_raw  = (color_q & LEFT_MASK) == LEFT_MASK;
  assign right_raw = (color_q & RIGHT_MASK) == RIGHT_MASK;
  assign lost_raw  = color_q == '0;

  flag_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_track (
    .clk(WF_CLK), .rst_n(rst_n), .raw(track_raw), .out(on_track)
  );
  flag_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk(WF_CLK), .rst_n(rst_n), .raw(left_raw), .out(left)
  );
  flag_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk(WF_CLK), .rst_n(rst_n), .raw(right_raw), .out(right)
  );
  flag_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lost (
    .clk(WF_CLK), .rst_n(rst_n), .raw(lost_raw), .out(lost)
  );

  // Outputs --------------------------------------------------------------------------

  assign cal_busy  = state_q != StIdle;
  assign cal_done  = done_q;
  assign threshold = thr_q;
  assign ir_color  = color_q;
  assign color_vld = vld_q;
  assign left_sum  = popcount4(color_q[7:4]);
  assign right_sum = popcount4(color_q[3:0]);

endmodule

// File: tb/tb_ir_line_classifier.sv
// Directed bench for ir_line_classifier with DB_CYCLES=4, CAL_SAMPLES=2.
module tb_ir_line_classifier;

  logic         WF_CLK;
  logic         rst_n;
  logic [135:0] ttd_bus;
  logic         sample_stb;
  logic         cal_req;
  logic         cal_busy;
  logic         cal_done;
  logic [16:0]  threshold;
  logic [7:0]   ir_color;
  logic         color_vld;
  logic         on_track;
  logic         left;
  logic         right;
  logic         lost;
  logic [2:0]   left_sum;
  logic [2:0]   right_sum;

  int total = 0;
  int bad   = 0;

  ir_line_classifier #(
    .CAL_SAMPLES(2),
    .DB_CYCLES  (4)
  ) dut (
    .WF_CLK    (WF_CLK),
    .rst_n     (rst_n),
    .ttd_bus   (ttd_bus),
    .sample_stb(sample_stb),
    .cal_req   (cal_req),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .threshold (threshold),
    .ir_color  (ir_color),
    .color_vld (color_vld),
    .on_track  (on_track),
    .left      (left),
    .right     (right),
    .lost      (lost),
    .left_sum  (left_sum),
    .right_sum (right_sum)
  );

  initial WF_CLK = 1'b0;
  always #5 WF_CLK = ~WF_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Each step passes one posedge and lands on the following negedge.
  task automatic step(input int n);
    repeat (n) @(negedge WF_CLK);
  endtask

  task automatic put(input logic [7:0] mask, input int unsigned hi, input int unsigned lo);
    for (int i = 0; i < 8; i++) ttd_bus[i*17 +: 17] = mask[i] ? 17'(hi) : 17'(lo);
  endtask

  task automatic stb(input logic [7:0] mask, input int unsigned hi, input int unsigned lo);
    put(mask, hi, lo);
    sample_stb = 1'b1;
    step(1);
    sample_stb = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    sample_stb = 1'b0;
    cal_req    = 1'b0;
    ttd_bus    = '0;

    // Reset state, then lost rises 4 clocks after release.
    step(20);
    chk("rst_thr", threshold, 2000);
    chk("rst_color", ir_color, 0);
    chk("rst_busy", cal_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_vld", color_vld, 0);
    chk("rst_lost", lost, 0);
    chk("rst_track", on_track, 0);
    rst_n = 1'b1;
    step(3);
    chk("lost_early", lost, 0);
    step(1);
    chk("lost_rise", lost, 1);

    // Calibration: two samples ch0..6=1000, ch7=9000 -> threshold 3000.
    cal_req = 1'b1;
    step(1);
    cal_req = 1'b0;
    chk("cal_busy_wait", cal_busy, 1);
    stb(8'h80, 9000, 1000);
    chk("cls_vld", color_vld, 1);
    chk("cls_80", ir_color, 8'h80);
    chk("cls_80_lsum", left_sum, 1);
    chk("cls_80_rsum", right_sum, 0);
    step(3);
    chk("vld_drop", color_vld, 0);
    // A sample mid-scan must not disturb calibration.
    put(8'h01, 10, 1000);
    sample_stb = 1'b1;
    step(1);
    sample_stb = 1'b0;
    put(8'h80, 9000, 1000);
    step(4);
    cal_req = 1'b1;  // ignored while busy
    step(1);
    cal_req = 1'b0;
    stb(8'h80, 9000, 1000);
    step(8);
    chk("commit_busy", cal_busy, 1);
    chk("commit_done_early", cal_done, 0);
    chk("commit_thr_old", threshold, 2000);
    step(1);
    chk("cal_done", cal_done, 1);
    chk("cal_thr", threshold, 3000);
    chk("cal_idle", cal_busy, 0);
    step(1);
    chk("cal_done_pulse", cal_done, 0);

    // Classification against 3000 and debounce latency.
    stb(8'h18, 4000, 100);
    chk("cls_18", ir_color, 8'h18);
    chk("cls_18_lsum", left_sum, 1);
    chk("cls_18_rsum", right_sum, 1);
    step(3);
    chk("track_early", on_track, 0);
    step(1);
    chk("track_rise", on_track, 1);
    stb(8'hF0, 4000, 100);
    chk("cls_f0", ir_color, 8'hF0);
    chk("cls_f0_lsum", left_sum, 4);
    chk("cls_f0_rsum", right_sum, 0);
    step(3);
    chk("left_early", left, 0);
    step(1);
    chk("left_rise", left, 1);
    chk("track_fall", on_track, 0);
    stb(8'h0F, 3001, 3000);
    chk("cls_0f_strict", ir_color, 8'h0F);
    chk("cls_0f_rsum", right_sum, 4);
    step(4);
    chk("right_rise", right, 1);
    chk("left_fall", left, 0);

    // Glitch: on_track raw high for only 3 clocks.
    stb(8'h18, 4000, 100);
    step(2);
    stb(8'h00, 0, 100);
    chk("glitch_a", on_track, 0);
    step(1);
    chk("glitch_b", on_track, 0);
    step(2);
    chk("glitch_lost_early", lost, 0);
    step(1);
    chk("glitch_lost_rise", lost, 1);
    chk("glitch_c", on_track, 0);

    // Reset during SCAN aborts and restores the default threshold.
    cal_req = 1'b1;
    step(1);
    cal_req = 1'b0;
    stb(8'h80, 9000, 1000);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", cal_busy, 0);
    chk("abort_thr", threshold, 2000);
    chk("abort_color", ir_color, 0);
    step(2);
    rst_n = 1'b1;

    // cal_req together with sample_stb: that sample is not a calibration sample.
    put(8'h00, 0, 100);
    cal_req    = 1'b1;
    sample_stb = 1'b1;
    step(1);
    cal_req    = 1'b0;
    sample_stb = 1'b0;
    chk("recal_busy", cal_busy, 1);
    stb(8'h80, 9000, 1000);
    step(9);
    stb(8'h80, 9000, 1000);
    step(8);
    chk("recal_thr_old", threshold, 2000);
    chk("recal_done_early", cal_done, 0);
    step(1);
    chk("recal_done", cal_done, 1);
    chk("recal_thr", threshold, 3000);

`ifdef IR_HYST_EN
    stb(8'h01, 4000, 100);
    chk("hyst_black", ir_color[0], 1);
    stb(8'h01, 2950, 100);
    chk("hyst_hold", ir_color[0], 1);
    stb(8'h01, 2850, 100);
    chk("hyst_white", ir_color[0], 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
